// File: rtl/rs_232_in.sv
// rs_232_in: 8N1 serial receiver, oversampled mid-bit sampling,
// one-byte holding register with ready/read handshake.
//
// Ports:
//   clock         : oversampling clock, OVERSAMPLE x bit rate
//   reset_n       : asynchronous active-low reset
//   enable        : receiver enable; low aborts a frame in progress
//   rxd           : serial line, idle high, asynchronous
//   read          : one-cycle strobe, consumes the held byte
//   data_out      : received byte
//   data_ready    : held byte valid and not yet read
//   framing_error : stop bit of the held byte was sampled low
//   overrun_error : a complete byte was dropped while data_ready was set
module rs_232_in #(
   parameter int OVERSAMPLE = 16
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       enable,
   input  logic       rxd,
   input  logic       read,
   output logic [7:0] data_out,
   output logic       data_ready,
   output logic       framing_error,
   output logic       overrun_error
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            rxd_m_q, rxd_s_q;
   logic            stop_stb;

   logic [7:0]      data_q, data_d;
   logic            rdy_q, rdy_d;
   logic            fe_q, fe_d;
   logic            oe_q, oe_d;

   // Two-flop synchronizer; resets to the idle (high) line level.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rxd_m_q <= 1'b1;
         rxd_s_q <= 1'b1;
      end else begin
         rxd_m_q <= rxd;
         rxd_s_q <= rxd_m_q;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   // Frame sequencing. cnt_q counts clocks since the last sample point,
   // so each state fires when cnt_q reaches its terminal value.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + 1'b1;
      bit_d    = bit_q;
      shift_d  = shift_q;
      stop_stb = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            if (!rxd_s_q) state_d = START;
         end
         START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               // High at mid-bit: the falling edge was a glitch.
               state_d = rxd_s_q ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               // LSB arrives first, so shift in from the top.
               shift_d = {rxd_s_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d    = '0;
               stop_stb = 1'b1;
               state_d  = rxd_s_q ? IDLE : WAIT_HIGH;
            end
         end
         WAIT_HIGH: begin
            // Break or bad stop bit: no new start until the line rises.
            cnt_d = '0;
            if (rxd_s_q) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      if (!enable) begin
         state_d = IDLE;
         cnt_d   = '0;
         bit_d   = '0;
      end
   end

   // Holding register and flags. A load on the same edge as a read
   // takes priority over the read's clear.
   always_comb begin
      data_d = data_q;
      rdy_d  = rdy_q;
      fe_d   = fe_q;
      oe_d   = oe_q;
      if (read && rdy_q) begin
         rdy_d = 1'b0;
         fe_d  = 1'b0;
         oe_d  = 1'b0;
      end
      if (stop_stb) begin
         if (!rdy_q || read) begin
            data_d = shift_q;
            rdy_d  = 1'b1;
            fe_d   = ~rxd_s_q;
            oe_d   = 1'b0;
         end else begin
            oe_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         data_q <= '0;
         rdy_q  <= 1'b0;
         fe_q   <= 1'b0;
         oe_q   <= 1'b0;
      end else begin
         data_q <= data_d;
         rdy_q  <= rdy_d;
         fe_q   <= fe_d;
         oe_q   <= oe_d;
      end
   end

   assign data_out      = data_q;
   assign data_ready    = rdy_q;
   assign framing_error = fe_q;
   assign overrun_error = oe_q;

endmodule

// File: tb/tb_rs_232_in.sv
// tb_rs_232_in: scoreboard bench for rs_232_in.
// Expected bytes are queued when sent and matched when the DUT loads them.
module tb_rs_232_in;

   localparam int OS = 16;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       enable;
   logic       rxd;
   logic       read;
   logic [7:0] data_out;
   logic       data_ready;
   logic       framing_error;
   logic       overrun_error;

   int n_chk  = 0;
   int n_fail = 0;

   logic [8:0] sb[$];
   logic       prev_rdy = 1'b0;
   logic [7:0] prev_data = 8'h00;

   rs_232_in #(.OVERSAMPLE(OS)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .enable        (enable),
      .rxd           (rxd),
      .read          (read),
      .data_out      (data_out),
      .data_ready    (data_ready),
      .framing_error (framing_error),
      .overrun_error (overrun_error)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // A load shows up as data_ready rising, or data_out changing while
   // data_ready stays set (load on the same edge as a read).
   always @(negedge clock) begin
      if (reset_n && data_ready &&
          (!prev_rdy || data_out != prev_data)) begin
         if (sb.size() == 0) begin
            chk("unexpected_byte_sb_size", sb.size(), 1);
         end else begin
            chk("byte_fe_data", {framing_error, data_out}, sb.pop_front());
         end
      end
      prev_rdy  = data_ready;
      prev_data = data_out;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Start bit, 8 data bits LSB first, stop bit, optional extra low
   // time, then two bit times of idle high.
   task automatic send(input logic [7:0] b, input logic stopv,
                       input int hold);
      rxd = 1'b0;
      wait_clk(OS);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         wait_clk(OS);
      end
      rxd = stopv;
      wait_clk(OS);
      if (hold > 0) wait_clk(hold);
      rxd = 1'b1;
      wait_clk(2 * OS);
   endtask

   task automatic pulse_read;
      read = 1'b1;
      wait_clk(1);
      read = 1'b0;
      wait_clk(1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      enable  = 1'b1;
      rxd     = 1'b1;
      read    = 1'b0;
      wait_clk(4);
      chk("rst_data", data_out, 8'h00);
      chk("rst_ready", data_ready, 0);
      chk("rst_fe", framing_error, 0);
      chk("rst_oe", overrun_error, 0);
      reset_n = 1'b1;
      wait_clk(4);

      // Clean frame with two stop bits.
      sb.push_back({1'b0, 8'hA5});
      send(8'hA5, 1'b1, OS);
      chk("a5_ready", data_ready, 1);
      chk("a5_fe", framing_error, 0);
      pulse_read();
      chk("a5_read_clr", data_ready, 0);

      // Short low glitch must not start a frame.
      rxd = 1'b0;
      wait_clk(4);
      rxd = 1'b1;
      wait_clk(40);
      chk("glitch_ready", data_ready, 0);
      sb.push_back({1'b0, 8'h3C});
      send(8'h3C, 1'b1, 0);
      chk("3c_data", data_out, 8'h3C);
      pulse_read();

      // Bad stop bit with the line held low afterwards.
      sb.push_back({1'b1, 8'h81});
      send(8'h81, 1'b0, 40);
      chk("81_fe", framing_error, 1);
      chk("81_data", data_out, 8'h81);
      pulse_read();
      chk("81_fe_clr", framing_error, 0);
      sb.push_back({1'b0, 8'h55});
      send(8'h55, 1'b1, 0);
      chk("55_fe", framing_error, 0);
      pulse_read();

      // Second byte dropped while the first is unread.
      sb.push_back({1'b0, 8'h12});
      send(8'h12, 1'b1, 0);
      send(8'h34, 1'b1, 0);
      chk("ovr_data", data_out, 8'h12);
      chk("ovr_oe", overrun_error, 1);
      chk("ovr_ready", data_ready, 1);
      pulse_read();
      chk("ovr_read_rdy", data_ready, 0);
      chk("ovr_read_oe", overrun_error, 0);

      // Read on the exact stop-sample edge of a following frame.
      sb.push_back({1'b0, 8'h66});
      send(8'h66, 1'b1, 0);
      sb.push_back({1'b0, 8'h77});
      fork
         send(8'h77, 1'b1, 0);
         begin
            wait_clk(9 * OS + 10);
            read = 1'b1;
            wait_clk(1);
            read = 1'b0;
         end
      join
      chk("77_data", data_out, 8'h77);
      chk("77_ready", data_ready, 1);
      chk("77_oe", overrun_error, 0);
      pulse_read();

      // Reset in the middle of a frame of all ones.
      rxd = 1'b0;
      wait_clk(OS);
      rxd = 1'b1;
      wait_clk(45);
      reset_n = 1'b0;
      wait_clk(3);
      reset_n = 1'b1;
      wait_clk(1);
      chk("midrst_data", data_out, 8'h00);
      chk("midrst_ready", data_ready, 0);
      wait_clk(200);
      chk("midrst_noload", data_ready, 0);
      sb.push_back({1'b0, 8'h0F});
      send(8'h0F, 1'b1, 0);
      chk("0f_data", data_out, 8'h0F);
      pulse_read();

      // Enable dropped mid-frame aborts the frame.
      rxd = 1'b0;
      wait_clk(OS + 40);
      enable = 1'b0;
      wait_clk(5);
      rxd = 1'b1;
      wait_clk(2);
      enable = 1'b1;
      wait_clk(200);
      chk("en_ready", data_ready, 0);
      chk("en_fe", framing_error, 0);
      chk("en_oe", overrun_error, 0);
      chk("en_data", data_out, 8'h0F);

      chk("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rs_232_in.md
# rs_232_in

Asynchronous serial receiver for the 8250 interface: the downstream partner of the 8-bit transmitter. It recovers start/stop framed bytes from the serial line and presents them in a one-byte holding register with a ready/read handshake. Line format matches the transmitter: one low start bit, 8 data bits LSB first, no parity, stop bit(s) high. The receiver runs from a 16× bit-rate clock (153.6 kHz for 9600 bit/s), checks only the first stop bit, and treats any further high bits as idle.

## Interface
- OVERSAMPLE, 16: clock cycles per bit; even, ≥ 8.
- clock  in  1  oversampling clock, OVERSAMPLE × bit rate
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  receiver enable
- rxd  in  1  serial line, idle high, asynchronous to clock
- read  in  1  one-cycle strobe: consume the held byte
- data_out  out  8  received byte
- data_ready  out  1  held byte valid, not yet read
- framing_error  out  1  stop bit of the held byte sampled low
- overrun_error  out  1  a complete byte was dropped because data_ready was still set

One clock; reset is asynchronous and active-low (clock port `clock`, reset port `reset_n`).

## Operation
- rxd passes through a 2-flop synchronizer. All logic uses the synchronized value rxd_s.
- FSM states are IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: when rxd_s = 0, go to START and clear the sample counter.
- START: at the mid-bit point (OVERSAMPLE/2 clocks in), if rxd_s = 0 go to DATA. Otherwise the event was a glitch: return to IDLE with no flags changed.
- DATA: sample rxd_s once every OVERSAMPLE clocks and shift it into the MSB of an 8-bit shifter (LSB-first line order). After the 8th sample, go to STOP.
- STOP: one OVERSAMPLE clocks later, sample the stop bit.
  - If data_ready = 0, or read is asserted in the same cycle: load data_out with the shifter, set data_ready, and set framing_error to the inverse of the stop bit.
  - Otherwise: leave data_out and framing_error unchanged and set overrun_error.
  - Next state is IDLE if the stop bit is 1, WAIT_HIGH if it is 0.
- WAIT_HIGH (break or framing error): stay until rxd_s = 1, then go to IDLE. A line held low never produces further bytes.
- read while data_ready = 1: clear data_ready, framing_error and overrun_error on that edge, except when a new byte loads on the same edge (the load wins, and overrun stays clear).
- read while data_ready = 0: ignored.
- enable = 0: the FSM is forced to IDLE and the counters clear, which aborts any frame in progress. data_out and the flags are retained, and read still works.
- Reset values: data_out = 0x00, data_ready = 0, framing_error = 0, overrun_error = 0, FSM = IDLE, both synchronizer flops = 1.
- Reset mid-frame: the partial byte is discarded and none of its outputs are affected after reset release.

## Timing
- Reference point: edge 0 is the first clock edge at which IDLE sees rxd_s = 0. This is 2 clocks after rxd falls.
- With OVERSAMPLE = 16:
  - start verify at edge 8;
  - data bit n (n = 0..7) sampled at edge 24 + 16n;
  - stop bit sampled at edge 152;
  - data_ready, data_out and framing_error are valid after edge 152.
- General case: verify at OVERSAMPLE/2; bit n at OVERSAMPLE/2 + OVERSAMPLE·(n+1); stop at OVERSAMPLE/2 + 9·OVERSAMPLE.
- The FSM is in IDLE from edge 153. A new start bit is accepted immediately, so one stop bit suffices and the transmitter's 2 stop bits are tolerated.
- read → flags cleared after the same edge (0-cycle latency). data_out holds its value until the next load.
- Rate tolerance: sampling at mid-bit tolerates about ±4.5 % cumulative rate error across a frame.

## Test plan
- Frame 0xA5, 16 clocks per bit, 2 stop bits → data_out = 0xA5, data_ready = 1 after edge 152, framing_error = 0; pulse read → data_ready = 0.
- rxd low for 4 clocks, then high → no data_ready, FSM back in IDLE. Then send 0x3C → 0x3C received correctly.
- Frame 0x81 with stop bit 0, line held low 40 more clocks, then high → data_out = 0x81, framing_error = 1. No second byte; the next frame 0x55 is received after the line returns high and read.
- 0x12 then 0x34 back-to-back with no read → data_out = 0x12, overrun_error = 1. A read clears both flags.
- read asserted on the exact stop-sample edge of a second frame 0x77 → data_out = 0x77, data_ready = 1, overrun_error = 0.
- reset_n low at edge 60 of frame 0xFF, released, then frame 0x0F → all outputs 0 after reset, then 0x0F received. Separately, enable dropped mid-frame aborts it with no flag change.
